// File: rtl/mem_wr_queue_pkg.sv
// rtl/mem_wr_queue_pkg.sv - shared sizes and queue entry type for the write queue
package mem_wr_queue_pkg;

    localparam int WIDTH     = 64;
    localparam int DEPTH     = 32;
    localparam int AW        = $clog2(DEPTH);
    localparam int SRCS      = 2;
    localparam int QDEPTH    = 4;
    localparam int LK_PORTS  = 2;
    localparam int WRQ_PTR_W = $clog2(QDEPTH);
    localparam int WRQ_CNT_W = WRQ_PTR_W + 1;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wrq_entry_t;

    // Power-of-two queue depth: truncation to the pointer width is the wrap.
    function automatic logic [WRQ_PTR_W-1:0] ptr_add(input logic [WRQ_PTR_W-1:0] ptr,
                                                     input logic [WRQ_CNT_W-1:0] off);
        return ptr + off[WRQ_PTR_W-1:0];
    endfunction

endpackage

// File: rtl/mem_wr_queue_if.sv
// rtl/mem_wr_queue_if.sv - producer, memory-port and lookup signals of the write queue
interface mem_wr_queue_if;
    import mem_wr_queue_pkg::*;

    logic [SRCS-1:0]                 src_valid;
    logic [SRCS-1:0][AW-1:0]         src_addr;
    logic [SRCS-1:0][WIDTH-1:0]      src_data;
    logic [SRCS-1:0]                 src_ready;
    logic                            wr_stall;
    logic                            mem_we;
    logic [AW-1:0]                   mem_waddr;
    logic [WIDTH-1:0]                mem_wdata;
    logic [LK_PORTS-1:0]             lk_en;
    logic [LK_PORTS-1:0][AW-1:0]     lk_addr;
    logic [LK_PORTS-1:0]             lk_hit;
    logic [LK_PORTS-1:0][WIDTH-1:0]  lk_data;
    logic [WRQ_CNT_W-1:0]            count;

    modport master (
        output src_valid, src_addr, src_data, wr_stall, lk_en, lk_addr,
        input  src_ready, mem_we, mem_waddr, mem_wdata, lk_hit, lk_data, count
    );

    modport slave (
        input  src_valid, src_addr, src_data, wr_stall, lk_en, lk_addr,
        output src_ready, mem_we, mem_waddr, mem_wdata, lk_hit, lk_data, count
    );

endinterface

// File: rtl/mem_wr_queue_fwd_match.sv
// rtl/mem_wr_queue_fwd_match.sv - youngest-match finder for one lookup port (WRQ_FWD_EN only)
`ifdef WRQ_FWD_EN
module wrq_fwd_match
    import mem_wr_queue_pkg::*;
(
    input  wrq_entry_t           entries [QDEPTH],
    input  logic [WRQ_CNT_W-1:0] occ,
    input  logic                 en,
    input  logic [AW-1:0]        addr,
    output logic                 hit,
    output logic [WIDTH-1:0]     data
);

    // entries[0] is the head; scanning upward lets the youngest match win.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (en && (WRQ_CNT_W'(k) < occ) && (entries[k].addr == addr)) begin
                hit  = 1'b1;
                data = entries[k].data;
            end
        end
    end

endmodule
`endif

// File: rtl/mem_wr_queue.sv
// rtl/mem_wr_queue.sv - in-order write queue draining one entry per cycle to the memory port
// Optional store-to-load lookup enabled by WRQ_FWD_EN.
module mem_wr_queue
    import mem_wr_queue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_wr_queue_if.slave bus
);

    logic [WRQ_PTR_W-1:0] head;
    logic [WRQ_PTR_W-1:0] tail;
    logic [WRQ_CNT_W-1:0] count_q;
    logic [WRQ_CNT_W-1:0] free;
    logic [WRQ_CNT_W-1:0] seen;
    logic [WRQ_CNT_W-1:0] n_acc;
    logic [SRCS-1:0]      ready;
    logic [SRCS-1:0]      accept;
    logic [WRQ_PTR_W-1:0] slot [SRCS];
    logic                 pop;
    wrq_entry_t           q [QDEPTH];

    // Ready depends only on the registered count and lower-index valids,
    // so a pop in the same cycle never opens a slot early.
    always_comb begin
        free  = WRQ_CNT_W'(QDEPTH) - count_q;
        seen  = '0;
        n_acc = '0;
        for (int i = 0; i < SRCS; i++) begin
            ready[i]  = (seen < free);
            accept[i] = bus.src_valid[i] && ready[i];
            slot[i]   = ptr_add(tail, n_acc);
            if (bus.src_valid[i]) seen = seen + WRQ_CNT_W'(1);
            if (accept[i]) n_acc = n_acc + WRQ_CNT_W'(1);
        end
    end

    assign pop = (count_q != '0) && !bus.wr_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int k = 0; k < QDEPTH; k++) q[k] <= '0;
        end else begin
            for (int i = 0; i < SRCS; i++) begin
                if (accept[i]) q[slot[i]] <= '{addr: bus.src_addr[i], data: bus.src_data[i]};
            end
            tail <= ptr_add(tail, n_acc);
            if (pop) head <= head + WRQ_PTR_W'(1);
            count_q <= count_q + n_acc - WRQ_CNT_W'(pop);
        end
    end

    assign bus.src_ready = ready;
    assign bus.mem_we    = pop;
    assign bus.mem_waddr = q[head].addr;
    assign bus.mem_wdata = q[head].data;
    assign bus.count     = count_q;

`ifdef WRQ_FWD_EN
    wrq_entry_t                     aged [QDEPTH];
    logic [LK_PORTS-1:0]            lk_hit_w;
    logic [LK_PORTS-1:0][WIDTH-1:0] lk_data_w;

    always_comb begin
        for (int k = 0; k < QDEPTH; k++) aged[k] = q[head + WRQ_PTR_W'(k)];
    end

    for (genvar p = 0; p < LK_PORTS; p++) begin : g_lk
        wrq_fwd_match u_match (
            .entries (aged),
            .occ     (count_q),
            .en      (bus.lk_en[p]),
            .addr    (bus.lk_addr[p]),
            .hit     (lk_hit_w[p]),
            .data    (lk_data_w[p])
        );
    end

    assign bus.lk_hit  = lk_hit_w;
    assign bus.lk_data = lk_data_w;
`else
    logic unused_lk;
    assign unused_lk   = ^{bus.lk_en, bus.lk_addr};
    assign bus.lk_hit  = '0;
    assign bus.lk_data = '0;
`endif

endmodule

// File: tb/tb_mem_wr_queue.sv
// tb/tb_mem_wr_queue.sv - directed self-checking bench for mem_wr_queue
module tb_mem_wr_queue;
    import mem_wr_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_wr_queue_if bus ();

    mem_wr_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.src_valid = '0;
        bus.src_addr  = '0;
        bus.src_data  = '0;
        bus.wr_stall  = 1'b0;
        bus.lk_en     = '0;
        bus.lk_addr   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
        total++; if (bus.mem_waddr !== 5'd0 || bus.mem_wdata !== 64'd0) begin bad++; $display("FAIL reset_wport got=%h/%h exp=0/0", bus.mem_waddr, bus.mem_wdata); end
        total++; if (bus.src_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", bus.src_ready); end
        total++; if (bus.lk_hit !== 2'b00 || bus.lk_data !== '0) begin bad++; $display("FAIL reset_lk got=%b exp=00", bus.lk_hit); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        @(negedge clk);
        bus.wr_stall = 1'b1;
        bus.src_valid = 2'b11;
        bus.src_addr[0] = 5'd1; bus.src_data[0] = 64'h1;
        bus.src_addr[1] = 5'd2; bus.src_data[1] = 64'h2;
        @(negedge clk);
        bus.src_valid = 2'b01;
        bus.src_addr[0] = 5'd3; bus.src_data[0] = 64'h3;
        @(negedge clk);
        bus.src_valid = 2'b00;
        bus.wr_stall = 1'b0;
        #1;
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL middrain_count got=%0d exp=3", bus.count); end
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL middrain_we got=%b exp=1", bus.mem_we); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL middrain_rst_we got=%b exp=0", bus.mem_we); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL middrain_rst_count got=%0d exp=0", bus.count); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.src_valid = 2'b01;
        bus.src_addr[0] = 5'd5; bus.src_data[0] = 64'hAA;
        @(negedge clk);
        bus.src_valid = 2'b00;
        #1;
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", bus.mem_we); end
        total++; if (bus.mem_waddr !== 5'd5) begin bad++; $display("FAIL single_addr got=%0d exp=5", bus.mem_waddr); end
        total++; if (bus.mem_wdata !== 64'hAA) begin bad++; $display("FAIL single_data got=%h exp=aa", bus.mem_wdata); end
        @(negedge clk);
        #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL single_we_after got=%b exp=0", bus.mem_we); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL single_count_after got=%0d exp=0", bus.count); end
    endtask

    task automatic test_priority_fill();
        logic [1:0] exp_rdy [3];
        exp_rdy[0] = 2'b11; exp_rdy[1] = 2'b11; exp_rdy[2] = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.wr_stall = 1'b1;
            bus.src_valid = 2'b11;
            bus.src_addr[0] = 5'(10 + 2*c); bus.src_data[0] = 64'(16'h10 + 32*c);
            bus.src_addr[1] = 5'(11 + 2*c); bus.src_data[1] = 64'(16'h20 + 32*c);
            #1;
            total++; if (bus.src_ready !== exp_rdy[c]) begin bad++; $display("FAIL fill_ready c=%0d got=%b exp=%b", c, bus.src_ready, exp_rdy[c]); end
            total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL fill_we_stalled c=%0d got=%b exp=0", c, bus.mem_we); end
        end
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    endtask

    task automatic test_full_with_pop();
        logic [63:0] exp_d [5];
        exp_d[0] = 64'h10; exp_d[1] = 64'h20; exp_d[2] = 64'h30; exp_d[3] = 64'h40; exp_d[4] = 64'h55;
        @(negedge clk);
        bus.wr_stall = 1'b0;
        bus.src_valid = 2'b01;
        bus.src_addr[0] = 5'd9; bus.src_data[0] = 64'h55;
        #1;
        total++; if (bus.src_ready[0] !== 1'b0) begin bad++; $display("FAIL fullpop_ready0 got=%b exp=0", bus.src_ready[0]); end
        total++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== exp_d[0]) begin bad++; $display("FAIL fullpop_head got=%b/%h exp=1/%h", bus.mem_we, bus.mem_wdata, exp_d[0]); end
        @(negedge clk);
        #1;
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL fullpop_count got=%0d exp=3", bus.count); end
        total++; if (bus.src_ready !== 2'b01) begin bad++; $display("FAIL fullpop_ready_next got=%b exp=01", bus.src_ready); end
        total++; if (bus.mem_wdata !== exp_d[1]) begin bad++; $display("FAIL fullpop_order i=1 got=%h exp=%h", bus.mem_wdata, exp_d[1]); end
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            bus.src_valid = 2'b00;
            #1;
            total++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== exp_d[i]) begin bad++; $display("FAIL fullpop_order i=%0d got=%b/%h exp=1/%h", i, bus.mem_we, bus.mem_wdata, exp_d[i]); end
        end
        @(negedge clk);
        #1;
        total++; if (bus.mem_we !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("FAIL fullpop_empty got=%b/%0d exp=0/0", bus.mem_we, bus.count); end
    endtask

    task automatic test_forwarding();
        logic [1:0]  exp_hit;
        logic [63:0] exp_d0;
`ifdef WRQ_FWD_EN
        exp_hit = 2'b01; exp_d0 = 64'h22;
`else
        exp_hit = 2'b00; exp_d0 = 64'h0;
`endif
        @(negedge clk);
        bus.wr_stall = 1'b1;
        bus.src_valid = 2'b01;
        bus.src_addr[0] = 5'd7; bus.src_data[0] = 64'h11;
        @(negedge clk);
        bus.src_data[0] = 64'h22;
        @(negedge clk);
        bus.src_valid = 2'b00;
        bus.lk_en = 2'b11;
        bus.lk_addr[0] = 5'd7; bus.lk_addr[1] = 5'd8;
        #1;
        total++; if (bus.lk_hit !== exp_hit) begin bad++; $display("FAIL fwd_hit got=%b exp=%b", bus.lk_hit, exp_hit); end
        total++; if (bus.lk_data[0] !== exp_d0) begin bad++; $display("FAIL fwd_data0 got=%h exp=%h", bus.lk_data[0], exp_d0); end
        total++; if (bus.lk_data[1] !== 64'h0) begin bad++; $display("FAIL fwd_data1_miss got=%h exp=0", bus.lk_data[1]); end
        bus.lk_en = 2'b10;
        #1;
        total++; if (bus.lk_hit !== 2'b00) begin bad++; $display("FAIL fwd_disabled_hit got=%b exp=00", bus.lk_hit); end
        @(negedge clk);
        bus.lk_en = 2'b00;
        bus.wr_stall = 1'b0;
        #1;
        total++; if (bus.mem_waddr !== 5'd7 || bus.mem_wdata !== 64'h11) begin bad++; $display("FAIL fwd_drain0 got=%0d/%h exp=7/11", bus.mem_waddr, bus.mem_wdata); end
        @(negedge clk);
        #1;
        total++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 64'h22) begin bad++; $display("FAIL fwd_drain1 got=%b/%h exp=1/22", bus.mem_we, bus.mem_wdata); end
        @(negedge clk);
    endtask

    task automatic test_same_address();
        logic [63:0] model_mem [32];
        int we_cycles = 0;
        for (int a = 0; a < 32; a++) model_mem[a] = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.wr_stall = 1'b0;
            bus.src_valid = (c < 2) ? 2'b11 : 2'b00;
            bus.src_addr[0] = 5'd3; bus.src_data[0] = 64'(2*c + 1);
            bus.src_addr[1] = 5'd3; bus.src_data[1] = 64'(2*c + 2);
            #1;
            if (bus.mem_we === 1'b1) begin
                we_cycles++;
                model_mem[bus.mem_waddr] = bus.mem_wdata;
            end
        end
        bus.src_valid = 2'b00;
        total++; if (we_cycles != 4) begin bad++; $display("FAIL same_addr_we_cycles got=%0d exp=4", we_cycles); end
        total++; if (model_mem[3] !== 64'd4) begin bad++; $display("FAIL same_addr_final got=%0d exp=4", model_mem[3]); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_drain();
        test_single_write();
        test_priority_fill();
        test_full_with_pop();
        test_forwarding();
        test_same_address();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
